// File: rtl/filter_gin_receiver.sv
// GIN receiver: pops a {data, tag} pair, delivers it to every matching PE, counts packets to done.
// Optional tag wildcards (all-ones row/col tag multicast) via `define GIN_TAG_WILDCARD_EN.
module filter_gin_receiver #(
    parameter int DATA_WIDTH    = 64,
    parameter int ROW_TAG_WIDTH = 4,
    parameter int COL_TAG_WIDTH = 4,
    parameter int NUM_ROWS      = 3,
    parameter int NUM_COLS      = 4,
    parameter int IDX_WIDTH     = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           total_words,
    output logic                           done,
    input  logic                           gin_fifo_empty,
    output logic                           re_from_gin_fifo,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic                           tags_fifo_empty,
    output logic                           re_from_tags_fifo,
    input  logic [ROW_TAG_WIDTH-1:0]       row_tag,
    input  logic [COL_TAG_WIDTH-1:0]       col_tag,
    input  logic                           cfg_we,
    input  logic                           cfg_is_col,
    input  logic [IDX_WIDTH-1:0]           cfg_idx,
    input  logic [ROW_TAG_WIDTH-1:0]       cfg_id,
    input  logic [NUM_ROWS*NUM_COLS-1:0]   pe_ready,
    output logic [NUM_ROWS*NUM_COLS-1:0]   pe_we,
    output logic [DATA_WIDTH-1:0]          pe_data
);

    localparam int NUM_PE = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CNT_WIDTH-1:0]     r_cnt;
    logic [CNT_WIDTH-1:0]     r_total;
    logic [NUM_PE-1:0]        r_pending;
    logic [DATA_WIDTH-1:0]    r_word;
    logic                     r_done;
    logic [ROW_TAG_WIDTH-1:0] r_row_id [NUM_ROWS];
    logic [COL_TAG_WIDTH-1:0] r_col_id [NUM_COLS];

    logic                     w_pop;
    logic                     w_row_wild;
    logic                     w_col_wild;
    logic [NUM_ROWS-1:0]      w_row_hit;
    logic [NUM_COLS-1:0]      w_col_hit;
    logic [NUM_PE-1:0]        w_mask;
    logic [NUM_PE-1:0]        w_pend_next;
    logic [CNT_WIDTH-1:0]     w_cnt_inc;

`ifdef GIN_TAG_WILDCARD_EN
    assign w_row_wild = (row_tag == {ROW_TAG_WIDTH{1'b1}});
    assign w_col_wild = (col_tag == {COL_TAG_WIDTH{1'b1}});
`else
    assign w_row_wild = 1'b0;
    assign w_col_wild = 1'b0;
`endif

    // Both FIFOs pop as one, only when a whole packet (word + tag) is available.
    assign w_pop             = (r_state == S_WAIT) && !gin_fifo_empty && !tags_fifo_empty;
    assign re_from_gin_fifo  = w_pop;
    assign re_from_tags_fifo = w_pop;

    assign w_pend_next = r_pending & ~pe_ready;
    assign w_cnt_inc   = r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    assign pe_we   = r_pending;
    assign pe_data = r_word;
    assign done    = r_done;

    // Destination mask: a PE is targeted when both its row ID and column ID match the head tag.
    always_comb begin
        w_row_hit = {NUM_ROWS{1'b0}};
        w_col_hit = {NUM_COLS{1'b0}};
        w_mask    = {NUM_PE{1'b0}};
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_row_hit[r] = w_row_wild || (r_row_id[r] == row_tag);
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            w_col_hit[c] = w_col_wild || (r_col_id[c] == col_tag);
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                w_mask[r*NUM_COLS+c] = w_row_hit[r] & w_col_hit[c];
            end
        end
    end

    // Transfer control, packet capture, per-PE delivery tracking and ID configuration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CNT_WIDTH{1'b0}};
            r_total   <= {CNT_WIDTH{1'b0}};
            r_pending <= {NUM_PE{1'b0}};
            r_word    <= {DATA_WIDTH{1'b0}};
            r_done    <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                r_row_id[r] <= ROW_TAG_WIDTH'(r);
            end
            for (int c = 0; c < NUM_COLS; c++) begin
                r_col_id[c] <= COL_TAG_WIDTH'(c);
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (total_words != {CNT_WIDTH{1'b0}}) begin
                            r_cnt   <= {CNT_WIDTH{1'b0}};
                            r_total <= total_words;
                            r_state <= S_WAIT;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end
                    // IDs are only reprogrammable between transfers; out-of-range indices match nothing.
                    if (cfg_we) begin
                        for (int r = 0; r < NUM_ROWS; r++) begin
                            if (!cfg_is_col && (int'(cfg_idx) == r)) begin
                                r_row_id[r] <= cfg_id;
                            end
                        end
                        for (int c = 0; c < NUM_COLS; c++) begin
                            if (cfg_is_col && (int'(cfg_idx) == c)) begin
                                r_col_id[c] <= COL_TAG_WIDTH'(cfg_id);
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (w_pop) begin
                        r_word    <= din;
                        r_pending <= w_mask;
                        r_state   <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    r_pending <= w_pend_next;
                    // An empty mask drops the packet after a single HOLD cycle.
                    if (w_pend_next == {NUM_PE{1'b0}}) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_total) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pending <= {NUM_PE{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_gin_receiver.sv
// Self-checking bench for filter_gin_receiver: directed vector table, corner sequences and
// randomized transfers compared cycle by cycle against a transaction-level reference model.
module tb_filter_gin_receiver;

    localparam int NPE = 12;

`ifdef GIN_TAG_WILDCARD_EN
    localparam bit WILD = 1'b1;
`else
    localparam bit WILD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [15:0]     total_words = 16'd0;
    logic            done;
    logic            gin_fifo_empty = 1'b1;
    logic            re_from_gin_fifo;
    logic [63:0]     din = 64'd0;
    logic            tags_fifo_empty = 1'b1;
    logic            re_from_tags_fifo;
    logic [3:0]      row_tag = 4'd0;
    logic [3:0]      col_tag = 4'd0;
    logic            cfg_we = 1'b0;
    logic            cfg_is_col = 1'b0;
    logic [3:0]      cfg_idx = 4'd0;
    logic [3:0]      cfg_id = 4'd0;
    logic [NPE-1:0]  pe_ready = '0;
    logic [NPE-1:0]  pe_we;
    logic [63:0]     pe_data;

    always #5 clk = ~clk;

    filter_gin_receiver dut (
        .clk(clk), .reset(reset), .start(start), .total_words(total_words), .done(done),
        .gin_fifo_empty(gin_fifo_empty), .re_from_gin_fifo(re_from_gin_fifo), .din(din),
        .tags_fifo_empty(tags_fifo_empty), .re_from_tags_fifo(re_from_tags_fifo),
        .row_tag(row_tag), .col_tag(col_tag), .cfg_we(cfg_we), .cfg_is_col(cfg_is_col),
        .cfg_idx(cfg_idx), .cfg_id(cfg_id), .pe_ready(pe_ready), .pe_we(pe_we), .pe_data(pe_data)
    );

    typedef struct {
        logic [3:0]     rt;
        logic [3:0]     ct;
        logic [63:0]    data;
        logic [NPE-1:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0]    gq[$];
    logic [7:0]     tq[$];
    logic [NPE-1:0] we_hist[$];
    int             pop_cnt;
    int             done_cnt;

    // reference model: transfer in progress, packet in flight, packets still owed
    logic [3:0]     m_row [3];
    logic [3:0]     m_col [4];
    logic           m_active, m_hold, m_done;
    logic [NPE-1:0] m_pend;
    logic [63:0]    m_word;
    int             m_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [NPE-1:0] calc_mask(input logic [3:0] rt, input logic [3:0] ct);
        logic [NPE-1:0] m = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if ((m_row[r] == rt || (WILD && rt == 4'hF)) && (m_col[c] == ct || (WILD && ct == 4'hF)))
                    m[r*4+c] = 1'b1;
        return m;
    endfunction

    function automatic logic [NPE-1:0] or_hist();
        logic [NPE-1:0] o = '0;
        foreach (we_hist[i]) o = o | we_hist[i];
        return o;
    endfunction

    function automatic int cnt_bit(input int b);
        int n = 0;
        foreach (we_hist[i]) if (we_hist[i][b]) n++;
        return n;
    endfunction

    function automatic int nz_cycles();
        int n = 0;
        foreach (we_hist[i]) if (we_hist[i] != '0) n++;
        return n;
    endfunction

    function automatic logic [3:0] rand_tag();
        if ($urandom_range(0, 5) == 0) return 4'hF;
        return 4'($urandom_range(0, 4));
    endfunction

    task automatic refresh();
        gin_fifo_empty  = (gq.size() == 0);
        din             = (gq.size() == 0) ? 64'd0 : gq[0];
        tags_fifo_empty = (tq.size() == 0);
        row_tag         = (tq.size() == 0) ? 4'd0 : tq[0][7:4];
        col_tag         = (tq.size() == 0) ? 4'd0 : tq[0][3:0];
    endtask

    task automatic push(input logic [63:0] d, input logic [3:0] rt, input logic [3:0] ct);
        gq.push_back(d);
        tq.push_back({rt, ct});
        refresh();
    endtask

    task automatic clr_obs();
        we_hist.delete();
        pop_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic rand_cfg();
        cfg_we     = ($urandom_range(0, 3) == 0);
        cfg_is_col = 1'($urandom_range(0, 1));
        cfg_idx    = 4'($urandom_range(0, 5));
        cfg_id     = rand_tag();
    endtask

    // One clock: compare against the model, advance the model, then let the FIFOs pop.
    task automatic cycle();
        logic           exp_pop, pg, pt, done_n;
        logic [NPE-1:0] exp_we;
        logic [7:0]     th;
        int             i;
        #1;
        exp_pop = m_active && !m_hold && gq.size() != 0 && tq.size() != 0;
        exp_we  = m_hold ? m_pend : '0;
        pg = re_from_gin_fifo;
        pt = re_from_tags_fifo;
        check("pop_data", 64'(pg), 64'(exp_pop));
        check("pop_tags", 64'(pt), 64'(exp_pop));
        check("pe_we", 64'(pe_we), 64'(exp_we));
        check("done", 64'(done), 64'(m_done));
        if (m_hold) check("pe_data", pe_data, m_word);
        we_hist.push_back(pe_we);
        if (pg) pop_cnt++;
        if (done) done_cnt++;

        done_n = 1'b0;
        if (!m_active) begin
            if (cfg_we) begin
                i = int'(cfg_idx);
                if (!cfg_is_col && i < 3) m_row[i] = cfg_id;
                else if (cfg_is_col && i < 4) m_col[i] = cfg_id;
            end
            if (start) begin
                if (total_words != 16'd0) begin
                    m_active = 1'b1;
                    m_left   = int'(total_words);
                end else begin
                    done_n = 1'b1;
                end
            end
        end else if (!m_hold) begin
            if (exp_pop) begin
                th     = tq[0];
                m_word = gq[0];
                m_pend = calc_mask(th[7:4], th[3:0]);
                m_hold = 1'b1;
            end
        end else begin
            m_pend = m_pend & ~pe_ready;
            if (m_pend == '0) begin
                m_hold = 1'b0;
                m_left--;
                if (m_left == 0) begin
                    m_active = 1'b0;
                    done_n   = 1'b1;
                end
            end
        end
        m_done = done_n;

        @(posedge clk);
        #1;
        if (pg && gq.size() != 0) void'(gq.pop_front());
        if (pt && tq.size() != 0) void'(tq.pop_front());
        refresh();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_pe_we", 64'(pe_we), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pop_data", 64'(re_from_gin_fifo), 64'd0);
        check("rst_pop_tags", 64'(re_from_tags_fifo), 64'd0);
        check("rst_pe_data", pe_data, 64'd0);
        for (int r = 0; r < 3; r++) m_row[r] = 4'(r);
        for (int c = 0; c < 4; c++) m_col[c] = 4'(c);
        m_active = 1'b0; m_hold = 1'b0; m_done = 1'b0;
        m_pend = '0; m_word = 64'd0; m_left = 0;
        gq.delete();
        tq.delete();
        refresh();
        start  = 1'b0;
        cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   npk, pushed, guard;

        tbl[0] = '{4'd1, 4'd2, 64'h0000_0000_0000_00A5, 12'h040};
        tbl[1] = '{4'd0, 4'd0, 64'h1111_2222_3333_4444, 12'h001};
        tbl[2] = '{4'd2, 4'd3, 64'hDEAD_BEEF_0000_0001, 12'h800};
        tbl[3] = '{4'd3, 4'd0, 64'h0000_0000_0000_0033, 12'h000};
        tbl[4] = '{4'd0, 4'd4, 64'h0000_0000_0000_0044, 12'h000};
        tbl[5] = '{4'hF, 4'hF, 64'hFFFF_0000_FFFF_0000, WILD ? 12'hFFF : 12'h000};
        tbl[6] = '{4'hF, 4'd1, 64'h0000_0000_0000_0066, WILD ? 12'h222 : 12'h000};
        tbl[7] = '{4'd2, 4'hF, 64'h0000_0000_0000_0077, WILD ? 12'hF00 : 12'h000};

        @(negedge clk);
        do_reset();

        // single-packet transfers with all PEs ready
        for (int v = 0; v < 8; v++) begin
            clr_obs();
            push(tbl[v].data, tbl[v].rt, tbl[v].ct);
            pe_ready    = '1;
            start       = 1'b1;
            total_words = 16'd1;
            cycle();
            start = 1'b0;
            repeat (4) cycle();
            check("tbl_we", 64'(or_hist()), 64'(tbl[v].exp));
            check("tbl_we_cycles", 64'(nz_cycles()), (tbl[v].exp != '0) ? 64'd1 : 64'd0);
            check("tbl_pops", 64'(pop_cnt), 64'd1);
            check("tbl_done", 64'(done_cnt), 64'd1);
        end

        // all column IDs = 5, PE 8 back-pressures for three HOLD cycles
        cfg_we = 1'b1; cfg_is_col = 1'b1; cfg_id = 4'd5;
        for (int c = 0; c < 4; c++) begin
            cfg_idx = 4'(c);
            cycle();
        end
        cfg_we = 1'b0;
        clr_obs();
        push(64'h0123_4567_89AB_CDEF, 4'd2, 4'd5);
        total_words = 16'd1;
        for (int k = 0; k < 9; k++) begin
            start = (k == 0);
            pe_ready = '1;
            if (k >= 2 && k < 5) pe_ready[8] = 1'b0;
            cycle();
        end
        check("bp_mask", 64'(or_hist()), 64'hF00);
        check("bp_bit8", 64'(cnt_bit(8)), 64'd4);
        check("bp_bit9", 64'(cnt_bit(9)), 64'd1);
        check("bp_bit11", 64'(cnt_bit(11)), 64'd1);
        check("bp_pops", 64'(pop_cnt), 64'd1);
        check("bp_done", 64'(done_cnt), 64'd1);

        // three packets that match no PE
        do_reset();
        clr_obs();
        for (int p = 0; p < 3; p++) push(64'(p + 100), 4'd7, 4'd7);
        total_words = 16'd3;
        for (int k = 0; k < 10; k++) begin
            start = (k == 0);
            pe_ready = NPE'($urandom);
            cycle();
        end
        check("drop_pops", 64'(pop_cnt), 64'd3);
        check("drop_we", 64'(or_hist()), 64'd0);
        check("drop_done", 64'(done_cnt), 64'd1);

        // tag present but data FIFO empty: nothing pops until both are present
        clr_obs();
        tq.push_back({4'd1, 4'd2});
        refresh();
        pe_ready = '1;
        total_words = 16'd1;
        for (int k = 0; k < 6; k++) begin
            start = (k == 0);
            cycle();
        end
        check("starve_pops", 64'(pop_cnt), 64'd0);
        gq.push_back(64'h77);
        refresh();
        repeat (5) cycle();
        check("starve_pops_after", 64'(pop_cnt), 64'd1);
        check("starve_we", 64'(or_hist()), 64'h040);
        check("starve_done", 64'(done_cnt), 64'd1);

        // zero-length transfer
        clr_obs();
        start = 1'b1; total_words = 16'd0;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        check("zero_done", 64'(done_cnt), 64'd1);
        check("zero_pops", 64'(pop_cnt), 64'd0);

        // reset while a packet is held with nothing accepted
        clr_obs();
        push(64'h5A5A, 4'd1, 4'd2);
        pe_ready = '0;
        total_words = 16'd1;
        for (int k = 0; k < 4; k++) begin
            start = (k == 0);
            cycle();
        end
        check("hold_we_before_rst", 64'(pe_we), 64'h040);
        do_reset();
        clr_obs();
        pe_ready = '1;
        repeat (4) cycle();
        check("rst_hold_done", 64'(done_cnt), 64'd0);
        check("rst_hold_we", 64'(or_hist()), 64'd0);

        // configuration attempted while waiting for data is ignored
        clr_obs();
        start = 1'b1; total_words = 16'd1;
        cycle();
        start = 1'b0;
        cfg_we = 1'b1; cfg_is_col = 1'b0; cfg_idx = 4'd1; cfg_id = 4'd9;
        repeat (2) cycle();
        cfg_we = 1'b0;
        push(64'hC0FFEE, 4'd1, 4'd2);
        repeat (4) cycle();
        check("wait_cfg_we", 64'(or_hist()), 64'h040);
        check("wait_cfg_done", 64'(done_cnt), 64'd1);

        // randomized transfers
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                rand_cfg();
                cycle();
            end
            rand_cfg();
            start = 1'b1;
            total_words = 16'($urandom_range(1, 5));
            npk = int'(total_words);
            pushed = 0;
            cycle();
            start = 1'b0;
            cfg_we = 1'b0;
            guard = 0;
            while ((m_active || m_done) && guard < 300) begin
                if (pushed < npk && $urandom_range(0, 2) == 0) begin
                    push(64'({$urandom, $urandom}), rand_tag(), rand_tag());
                    pushed++;
                end
                pe_ready    = NPE'($urandom);
                start       = m_active && ($urandom_range(0, 3) == 0);
                total_words = 16'($urandom);
                rand_cfg();
                cycle();
                guard++;
            end
            start = 1'b0;
            cfg_we = 1'b0;
            check("rand_timeout", 64'(guard < 300), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
